// File: rtl/ldtu_pkg.sv
// Shared definitions for the LiTe-DTU output FIFO: FSM state encoding and default
// idle/sync words presented to the serializer.
package ldtu_pkg;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } ldtu_state_e;

    localparam logic [31:0] LDTU_IDLE_WORD = 32'hEAAAAAAA;
    localparam logic [31:0] LDTU_SYNC_WORD = 32'h5A5A5A5A;

endpackage

// File: rtl/ldtu_fifo_mem.sv
// DEPTH x 32 storage for the output FIFO: one synchronous write port and one
// asynchronous read port. No reset; validity is tracked by the owner's pointers.
module ldtu_fifo_mem
    import ldtu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ldtu_output_fifo.sv
// LiTe-DTU output FIFO: sync-word alignment, normal/fallback write selection, flush on
// stream switch. Optional macro LDTU_OUTFIFO_STATS_EN adds a saturating drop_count output.
module ldtu_output_fifo
    import ldtu_pkg::*;
#(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] IDLE_WORD  = LDTU_IDLE_WORD,
    parameter logic [31:0] SYNC_WORD  = LDTU_SYNC_WORD,
    parameter int          SYNC_WORDS = 16
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        fallback,
    input  logic [31:0] DATA_32,
    input  logic        Load,
    input  logic [31:0] DATA_32_FB,
    input  logic        Load_FB,
    input  logic        word_req,
    output logic [31:0] DATA_out,
    output logic        out_valid,
    output logic        Full,
    output logic        Empty,
`ifdef LDTU_OUTFIFO_STATS_EN
    output logic [7:0]  drop_count,
`endif
    output logic        Overflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(SYNC_WORDS + 1);

    ldtu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [31:0]      data_q, data_d;
    logic             vld_q, vld_d;
    logic             ovf_q, ovf_d;
    logic             fb_q;

    logic             ptr_empty, ptr_full;
    logic             sel_load, fb_chg;
    logic [31:0]      sel_data, mem_rdata;
    logic             mem_we, drop;

    assign sel_load  = fallback ? Load_FB : Load;
    assign sel_data  = fallback ? DATA_32_FB : DATA_32;
    assign fb_chg    = fallback ^ fb_q;
    assign ptr_empty = (wr_ptr_q == rd_ptr_q);
    assign ptr_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    ldtu_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (CLK),
        .we_i    (mem_we & ~reset),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (sel_data),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        data_d   = data_q;
        vld_d    = 1'b0;
        mem_we   = 1'b0;
        drop     = 1'b0;
        unique case (state_q)
            ST_SYNC: begin
                if (word_req) begin
                    data_d = SYNC_WORD;
                    vld_d  = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(SYNC_WORDS - 1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (word_req) begin
                    vld_d = 1'b1;
                    if (!ptr_empty) begin
                        data_d   = mem_rdata;
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end else begin
                        data_d = IDLE_WORD;
                    end
                end
                // A read in the same cycle frees the slot, so a full FIFO still accepts.
                if (sel_load) begin
                    if (!ptr_full || word_req) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                if (fb_chg) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (word_req) begin
                    data_d = IDLE_WORD;
                    vld_d  = 1'b1;
                end
                rd_ptr_d = wr_ptr_q;
                state_d  = ST_RUN;
            end
            default: state_d = ST_SYNC;
        endcase
        ovf_d = ovf_q | drop;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= ST_SYNC;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            data_q   <= IDLE_WORD;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
            ovf_q    <= ovf_d;
        end
    end

    // Tracked through reset and SYNC so entering RUN never sees a stale edge.
    always_ff @(posedge CLK) begin
        fb_q <= fallback;
    end

`ifdef LDTU_OUTFIFO_STATS_EN
    logic [7:0] drop_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            drop_q <= '0;
        end else if (drop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign drop_count = drop_q;
`endif

    // FLUSH reports empty for its whole cycle; the pointers catch up at its end.
    assign Empty     = ptr_empty | (state_q == ST_FLUSH);
    assign Full      = ptr_full & (state_q != ST_FLUSH);
    assign DATA_out  = data_q;
    assign out_valid = vld_q;
    assign Overflow  = ovf_q;

endmodule

// File: tb/tb_ldtu_output_fifo.sv
// Scoreboard bench for ldtu_output_fifo: queue-based reference model, directed scenarios
// followed by randomized traffic with stream switches and resets.
module tb_ldtu_output_fifo;

    localparam int          DEPTH = 8;
    localparam logic [31:0] IDLE  = 32'hEAAAAAAA;
    localparam logic [31:0] SYNCW = 32'h5A5A5A5A;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        fallback = 1'b0;
    logic [31:0] DATA_32 = '0;
    logic        Load = 1'b0;
    logic [31:0] DATA_32_FB = '0;
    logic        Load_FB = 1'b0;
    logic        word_req = 1'b0;
    logic [31:0] DATA_out;
    logic        out_valid, Full, Empty, Overflow;
`ifdef LDTU_OUTFIFO_STATS_EN
    logic [7:0]  drop_count;
`endif

    ldtu_output_fifo #(.DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .fallback   (fallback),
        .DATA_32    (DATA_32),
        .Load       (Load),
        .DATA_32_FB (DATA_32_FB),
        .Load_FB    (Load_FB),
        .word_req   (word_req),
        .DATA_out   (DATA_out),
        .out_valid  (out_valid),
        .Full       (Full),
        .Empty      (Empty),
`ifdef LDTU_OUTFIFO_STATS_EN
        .drop_count (drop_count),
`endif
        .Overflow   (Overflow)
    );

    always #5 CLK = ~CLK;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];

    // Reference model: mode 0 = alignment, 1 = streaming, 2 = one-cycle flush.
    int          m_mode = 0;
    int          m_cnt = 0;
    logic [31:0] m_q[$];
    bit          m_ovf = 0;
    int          m_drops = 0;
    logic        m_fbprev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_cycle();
        logic        fbchg, ld;
        logic [31:0] din;
        int          sz;
        fbchg = (fallback != m_fbprev);
        ld    = fallback ? Load_FB : Load;
        din   = fallback ? DATA_32_FB : DATA_32;
        sz    = m_q.size();
        if (reset) begin
            m_mode = 0; m_cnt = 0; m_q.delete(); m_ovf = 0; m_drops = 0;
        end else if (m_mode == 0) begin
            if (word_req) begin
                exp_q.push_back(SYNCW);
                m_cnt++;
                if (m_cnt == 16) m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (word_req) begin
                if (sz > 0) exp_q.push_back(m_q.pop_front());
                else        exp_q.push_back(IDLE);
            end
            if (ld) begin
                if (sz < DEPTH || word_req) m_q.push_back(din);
                else begin m_ovf = 1; m_drops++; end
            end
            if (fbchg) m_mode = 2;
        end else begin
            if (word_req) exp_q.push_back(IDLE);
            m_q.delete();
            m_mode = 1;
        end
        m_fbprev = fallback;
    endfunction

    task automatic step(input logic rst, input logic ld, input logic [31:0] d,
                        input logic ldfb, input logic [31:0] dfb, input logic req, input logic fb);
        logic exp_empty, exp_full;
        reset = rst; Load = ld; DATA_32 = d; Load_FB = ldfb; DATA_32_FB = dfb;
        word_req = req; fallback = fb;
        model_cycle();
        @(posedge CLK);
        #1;
        exp_empty = (m_q.size() == 0) || (m_mode == 2);
        exp_full  = (m_q.size() == DEPTH) && (m_mode != 2);
        chk("Empty", 32'(Empty), 32'(exp_empty));
        chk("Full", 32'(Full), 32'(exp_full));
        chk("Overflow", 32'(Overflow), 32'(m_ovf));
        chk("out_valid", 32'(out_valid), 32'(req & ~rst));
`ifdef LDTU_OUTFIFO_STATS_EN
        chk("drop_count", 32'(drop_count), 32'((m_drops > 255) ? 255 : m_drops));
`endif
    endtask

    // Monitor: pops one expected word per out_valid; otherwise DATA_out must hold.
    logic [31:0] last_data = IDLE;
    always @(negedge CLK) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_valid: got %h, expected no output", DATA_out);
            end else begin
                chk("DATA_out", DATA_out, exp_q.pop_front());
            end
        end
        if (reset) last_data = IDLE;
        else if (out_valid === 1'b1) last_data = DATA_out;
        else chk("DATA_out_hold", DATA_out, last_data);
    end

    initial begin
        logic fb;
        logic rq;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_DATA_out", DATA_out, IDLE);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_Empty", 32'(Empty), 32'd1);

        // Alignment: 16 sync words, writes ignored, then idle.
        for (int i = 0; i < 16; i++) begin
            step(0, 1, $urandom, 0, 0, 1, 0);
            if (i % 3 == 0) step(0, 1, $urandom, 0, 0, 0, 0);
        end
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        step(0, 1, 32'h11111111, 0, 0, 0, 0);
        step(0, 1, 32'h22222222, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);

        // Fill past full, then drain.
        for (int i = 0; i < 9; i++) step(0, 1, 32'h30000000 + 32'(i), 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1, 0);

        // Simultaneous write and read while full; empty write+read.
        step(0, 1, 32'h40000000, 0, 0, 1, 0);
        for (int i = 1; i < 8; i++) step(0, 1, 32'h40000000 + 32'(i), 0, 0, 0, 0);
        step(0, 1, 32'hAAAA0009, 0, 0, 1, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 1, 0);

        // Stream switch flushes stored words.
        for (int i = 0; i < 3; i++) step(0, 1, 32'h50000000 + 32'(i), 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 32'h5000DEAD, 1, 32'hDEADBEEF, 0, 1);
        step(0, 1, 32'h5000BEEF, 1, 32'h0C000123, 0, 1);
        step(0, 1, 32'h5000CAFE, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);

        // Reset with words stored.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 32'h60000000 + 32'(i), 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("midrst_DATA_out", DATA_out, IDLE);
        chk("midrst_Empty", 32'(Empty), 32'd1);

        fb = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) fb = ~fb;
            if ((i / 250) % 2 == 0) rq = ($urandom_range(0, 4) == 0);
            else                    rq = ($urandom_range(0, 4) != 0);
            step($urandom_range(0, 599) == 0, 1'($urandom), $urandom,
                 1'($urandom), $urandom, rq, fb);
        end

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, fb);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
